id_ex_pipe_reg: RTL

- Parametrised ID->EX pipeline stage for the StupidCPU core.
- Replaces the fixed stall-vector stage with a valid/ready handshake and an optional 2-entry skid buffer.
- Adds memory-hazard tracking, selectable between conservative (stall on any outstanding mem op) and precise (stall only on a register match).
- Sits between the decoder and the ALU/EX stage; raises stall_req to the pipeline controller.

---
 rtl/id_ex_pipe_reg_pkg.sv | 39 +++
 rtl/id_ex_pipe_reg_skid_buf.sv | 88 ++++++++
 rtl/id_ex_pipe_reg.sv | 111 +++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared opcodes and payload field layout for the StupidCPU ID->EX stage.
// Payload order, MSB first: {pc, aluop, alusel, reg1, reg2, imm}.
package id_ex_pipe_reg_pkg;

  localparam logic [7:0] INST_NOP   = 8'h00;
  localparam logic [7:0] INST_LOAD  = 8'h20;
  localparam logic [7:0] INST_SAVE  = 8'h21;
  localparam logic [2:0] ALUSEL_NOP = 3'b000;

  typedef enum logic {
    HZ_CONSERVATIVE = 1'b0,
    HZ_PRECISE      = 1'b1
  } hazard_mode_e;

  function automatic int imm_lsb();
    return 0;
  endfunction

  function automatic int reg2_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int reg1_lsb(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int alusel_lsb(input int data_w);
    return 3 * data_w;
  endfunction

  function automatic int aluop_lsb(input int data_w, input int sel_w);
    return 3 * data_w + sel_w;
  endfunction

  function automatic int pc_lsb(input int data_w, input int op_w, input int sel_w);
    return 3 * data_w + sel_w + op_w;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_skid_buf.sv
// Output register plus optional skid entry with a valid/ready handshake.
// The tag sideband is only reported at the moment an entry enters the output register.
module pipe_skid_buf #(
  parameter int              W       = 8,
  parameter int              TAG_W   = 1,
  parameter int              SKID    = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic             load_o,
  output logic [TAG_W-1:0] load_tag_o
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_q, out_d;
  logic             skid_valid_q, skid_valid_d;
  logic [W-1:0]     skid_q, skid_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             push_s;
  logic             out_free_s;

  assign in_ready_o  = (SKID != 0) ? !skid_valid_q : (!out_valid_q | out_ready_i);
  assign push_s      = in_valid_i & in_ready_o;
  assign out_free_s  = !out_valid_q | out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign load_o      = !clr_i & out_free_s & (skid_valid_q | push_s);
  assign load_tag_o  = skid_valid_q ? skid_tag_q : in_tag_i;

  // Next-state: a held skid entry always drains before any new input, preserving order.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_tag_d   = skid_tag_q;
    if (clr_i) begin
      out_valid_d  = 1'b0;
      out_d        = RST_VAL;
      skid_valid_d = 1'b0;
      skid_d       = RST_VAL;
      skid_tag_d   = '0;
    end else if (out_free_s) begin
      out_valid_d  = skid_valid_q | push_s;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_d = skid_q;
      end else if (push_s) begin
        out_d = in_data_i;
      end else begin
        out_d = out_q;
      end
    end else if (push_s && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data_i;
      skid_tag_d   = in_tag_i;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= RST_VAL;
      skid_valid_q <= 1'b0;
      skid_q       <= RST_VAL;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline stage: handshake/skid buffering, flush, and load-use hazard tracking.
// Flush clears the payload path only; an outstanding mem op predates the branch.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int OP_W        = 8,
  parameter int SEL_W       = 3,
  parameter int SKID        = 1,
  parameter int HAZARD_MODE = 1,
  parameter int PAYLOAD_W   = 4 * DATA_W + OP_W + SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic                  in_wreg,
  input  logic                  in_is_mem,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic                  in_rs1_en,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_rs2_en,
  input  logic                  flush,
  input  logic                  load_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic                  stall_req
);

  localparam int ALUOP_LSB  = aluop_lsb(DATA_W, SEL_W);
  localparam int ALUSEL_LSB = alusel_lsb(DATA_W);
  localparam int BUF_W      = PAYLOAD_W + REG_ADDR_W + 1;
  localparam int TAG_W      = REG_ADDR_W + 1;

  localparam logic [PAYLOAD_W-1:0] RST_PAYLOAD =
      (PAYLOAD_W'(OP_W'(INST_NOP)) << ALUOP_LSB) |
      (PAYLOAD_W'(SEL_W'(ALUSEL_NOP)) << ALUSEL_LSB);
  localparam logic [BUF_W-1:0] BUF_RST = {1'b0, {REG_ADDR_W{1'b0}}, RST_PAYLOAD};

  logic                  pending_q, pending_d;
  logic [REG_ADDR_W-1:0] pend_wd_q, pend_wd_d;
  logic                  rs1_hit_s, rs2_hit_s, hazard_s;
  logic                  buf_ready_s, buf_load_s, buf_out_valid_s;
  logic [BUF_W-1:0]      buf_out_s;
  logic [TAG_W-1:0]      load_tag_s;

  assign rs1_hit_s = in_rs1_en & (in_rs1 == pend_wd_q) & (pend_wd_q != {REG_ADDR_W{1'b0}});
  assign rs2_hit_s = in_rs2_en & (in_rs2 == pend_wd_q) & (pend_wd_q != {REG_ADDR_W{1'b0}});
  assign hazard_s  = pending_q & in_valid &
                     ((HAZARD_MODE == int'(HZ_PRECISE)) ? (rs1_hit_s | rs2_hit_s) : 1'b1);

  assign in_ready  = buf_ready_s & !hazard_s;
  assign stall_req = hazard_s;

  pipe_skid_buf #(
    .W       (BUF_W),
    .TAG_W   (TAG_W),
    .SKID    (SKID),
    .RST_VAL (BUF_RST)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (flush),
    .in_valid_i  (in_valid & !hazard_s),
    .in_ready_o  (buf_ready_s),
    .in_data_i   ({in_wreg, in_wd, in_payload}),
    .in_tag_i    ({in_is_mem, in_wd}),
    .out_valid_o (buf_out_valid_s),
    .out_ready_i (out_ready),
    .out_data_o  (buf_out_s),
    .load_o      (buf_load_s),
    .load_tag_o  (load_tag_s)
  );

  assign out_valid   = buf_out_valid_s;
  assign out_payload = buf_out_s[PAYLOAD_W-1:0];
  assign out_wd      = buf_out_s[PAYLOAD_W +: REG_ADDR_W];
  assign out_wreg    = buf_out_s[BUF_W-1] & buf_out_valid_s;

  // A mem op issuing this cycle wins over a same-cycle load_done of the older one.
  always_comb begin
    pending_d = pending_q;
    pend_wd_d = pend_wd_q;
    if (buf_load_s && load_tag_s[TAG_W-1]) begin
      pending_d = 1'b1;
      pend_wd_d = load_tag_s[REG_ADDR_W-1:0];
    end else if (load_done) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Hazard tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      pend_wd_q <= {REG_ADDR_W{1'b0}};
    end else begin
      pending_q <= pending_d;
      pend_wd_q <= pend_wd_d;
    end
  end

endmodule
